// File: rtl/fast_control_rx.sv
// fast_control_rx
//   Receive-side decoder for the Hamming(8,4)-protected fast-control stream.
//   Each BX carries one 16-bit word: [7:0] command byte, [15:8] aux byte.
//   Single-bit errors are corrected per byte; words with an uncorrectable
//   byte are dropped and flagged. Decoded commands become single-cycle
//   strobes, and a local BX counter is locked to the received BCRs.
//
// Ports
//   clk_bx          BX clock, one encoded word per cycle
//   reset           asynchronous, active-high reset
//   fc_stream_enc   encoded input word
//   orb_length      orbit length in BX (quasi-static)
//   cnt_clear       synchronous clear of the error counters
//   bcr, l1a, link_reset, buffer_clear   command strobes (3 cycles after input)
//   fc_aux          last good aux nibble
//   bx_id           local BX number, aligned with the strobes
//   locked          BX counter is locked to the BCR stream
//   dec_err         pulse for a word with an uncorrectable byte
//   n_corrected, n_uncorrectable, n_misalign   saturating error counters
module fast_control_rx #(
  parameter int LOCK_COUNT = 4,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                 clk_bx,
  input  logic                 reset,
  input  logic [15:0]          fc_stream_enc,
  input  logic [11:0]          orb_length,
  input  logic                 cnt_clear,
  output logic                 bcr,
  output logic                 l1a,
  output logic                 link_reset,
  output logic                 buffer_clear,
  output logic [3:0]           fc_aux,
  output logic [11:0]          bx_id,
  output logic                 locked,
  output logic                 dec_err,
  output logic [CNT_WIDTH-1:0] n_corrected,
  output logic [CNT_WIDTH-1:0] n_uncorrectable,
  output logic [CNT_WIDTH-1:0] n_misalign
);

  localparam int GW = $clog2(LOCK_COUNT + 1) + 1;

  typedef enum logic [1:0] {
    ST_UNLOCKED = 2'd0,
    ST_LOCKING  = 2'd1,
    ST_LOCKED   = 2'd2
  } state_t;

  typedef struct packed {
    logic [3:0] data;
    logic       corrected;
    logic       uncorrectable;
  } dec_t;

  // Byte layout: e0 overall parity, e1 p1, e2 p2, e3 d0, e4 p3, e5 d1, e6 d2, e7 d3.
  // The syndrome is the bit position in error (0 = the overall parity bit),
  // valid only when the overall parity q also fails.
  function automatic dec_t hamming84_dec(input logic [7:0] e);
    logic [2:0] syn;
    logic       q;
    logic [7:0] fixed;
    dec_t       r;
    syn   = {e[4] ^ e[5] ^ e[6] ^ e[7],
             e[2] ^ e[3] ^ e[6] ^ e[7],
             e[1] ^ e[3] ^ e[5] ^ e[7]};
    q     = ^e;
    fixed = q ? (e ^ (8'b0000_0001 << syn)) : e;
    r.data          = {fixed[7], fixed[6], fixed[5], fixed[3]};
    r.corrected     = q;
    r.uncorrectable = ~q & (syn != 3'd0);
    return r;
  endfunction

  // Saturating add of 0..2 to an error counter.
  function automatic logic [CNT_WIDTH-1:0] sat_add(input logic [CNT_WIDTH-1:0] c,
                                                   input logic [1:0] inc);
    logic [CNT_WIDTH:0] sum;
    sum = {1'b0, c} + {{(CNT_WIDTH-1){1'b0}}, inc};
    return sum[CNT_WIDTH] ? {CNT_WIDTH{1'b1}} : sum[CNT_WIDTH-1:0];
  endfunction

  logic [15:0]   enc_r;
  logic [3:0]    cmd_r;
  logic [3:0]    aux_r;
  logic          uncorr_r;
  logic [1:0]    ncorr_r;
  state_t        state_r;
  state_t        state_nx_s;
  logic [GW-1:0] good_r;
  logic [GW-1:0] good_nx_s;
  logic          misalign_evt_s;
  logic [11:0]   bx_nx_s;
  logic          word_valid_s;
  logic          valid_bcr_s;
  logic          orb_ok_s;
  logic [11:0]   orb_last_s;
  logic          on_time_s;
  logic          wrap_s;
  dec_t          cmd_dec_s;
  dec_t          aux_dec_s;

  assign cmd_dec_s = hamming84_dec(enc_r[7:0]);
  assign aux_dec_s = hamming84_dec(enc_r[15:8]);

  // Stage 1 input register and stage 2 decode register.
  always_ff @(posedge clk_bx or posedge reset) begin
    if (reset) begin
      enc_r    <= 16'h0000;
      cmd_r    <= 4'h0;
      aux_r    <= 4'h0;
      uncorr_r <= 1'b0;
      ncorr_r  <= 2'd0;
    end else begin
      enc_r    <= fc_stream_enc;
      cmd_r    <= cmd_dec_s.data;
      aux_r    <= aux_dec_s.data;
      uncorr_r <= cmd_dec_s.uncorrectable | aux_dec_s.uncorrectable;
      ncorr_r  <= {1'b0, cmd_dec_s.corrected} + {1'b0, aux_dec_s.corrected};
    end
  end

  assign word_valid_s = ~uncorr_r;
  assign valid_bcr_s  = word_valid_s & cmd_r[0];
  assign orb_ok_s     = (orb_length >= 12'd2);
  assign orb_last_s   = orb_length - 12'd1;
  // bx_id here is the value of the previous word's cycle.
  assign on_time_s    = (bx_id == orb_last_s);
  // Using >= lets the counter recover if orb_length shrinks below bx_id.
  assign wrap_s       = (bx_id >= orb_last_s);

  // Next BX number: BCR re-zeroes, otherwise count and wrap at the orbit end.
  always_comb begin
    bx_nx_s = 12'd0;
    if (!orb_ok_s) begin
      bx_nx_s = 12'd0;
    end else if (valid_bcr_s || wrap_s) begin
      bx_nx_s = 12'd0;
    end else begin
      bx_nx_s = bx_id + 12'd1;
    end
  end

  // Lock state machine next-state logic.
  always_comb begin
    state_nx_s     = state_r;
    good_nx_s      = good_r;
    misalign_evt_s = 1'b0;
    case (state_r)
      ST_UNLOCKED: begin
        if (valid_bcr_s) begin
          state_nx_s = ST_LOCKING;
          good_nx_s  = GW'(1);
        end else begin
          good_nx_s  = GW'(0);
        end
      end
      ST_LOCKING: begin
        if (valid_bcr_s && on_time_s) begin
          good_nx_s = good_r + GW'(1);
          if (good_r + GW'(1) >= GW'(LOCK_COUNT)) begin
            state_nx_s = ST_LOCKED;
          end else begin
            state_nx_s = ST_LOCKING;
          end
        end else if (valid_bcr_s) begin
          good_nx_s = GW'(1);
        end else if (wrap_s) begin
          state_nx_s = ST_UNLOCKED;
          good_nx_s  = GW'(0);
        end else begin
          good_nx_s  = good_r;
        end
      end
      ST_LOCKED: begin
        if ((valid_bcr_s && !on_time_s) || (!valid_bcr_s && wrap_s)) begin
          misalign_evt_s = 1'b1;
          state_nx_s     = ST_UNLOCKED;
          good_nx_s      = GW'(0);
        end else begin
          state_nx_s     = ST_LOCKED;
        end
      end
      default: begin
        state_nx_s = ST_UNLOCKED;
        good_nx_s  = GW'(0);
      end
    endcase
    // A degenerate orbit length disables locking entirely.
    if (!orb_ok_s) begin
      state_nx_s     = ST_UNLOCKED;
      good_nx_s      = GW'(0);
      misalign_evt_s = 1'b0;
    end else begin
      misalign_evt_s = misalign_evt_s;
    end
  end

  // Stage 3: strobes, BX counter, lock state and error counters.
  always_ff @(posedge clk_bx or posedge reset) begin
    if (reset) begin
      bcr             <= 1'b0;
      l1a             <= 1'b0;
      link_reset      <= 1'b0;
      buffer_clear    <= 1'b0;
      fc_aux          <= 4'h0;
      bx_id           <= 12'd0;
      locked          <= 1'b0;
      dec_err         <= 1'b0;
      state_r         <= ST_UNLOCKED;
      good_r          <= {GW{1'b0}};
      n_corrected     <= {CNT_WIDTH{1'b0}};
      n_uncorrectable <= {CNT_WIDTH{1'b0}};
      n_misalign      <= {CNT_WIDTH{1'b0}};
    end else begin
      bcr          <= word_valid_s & cmd_r[0];
      l1a          <= word_valid_s & cmd_r[1];
      link_reset   <= word_valid_s & cmd_r[2];
      buffer_clear <= word_valid_s & cmd_r[3];
      fc_aux       <= word_valid_s ? aux_r : fc_aux;
      dec_err      <= uncorr_r;
      bx_id        <= bx_nx_s;
      state_r      <= state_nx_s;
      good_r       <= good_nx_s;
      locked       <= (state_nx_s == ST_LOCKED);
      if (cnt_clear) begin
        n_corrected     <= {CNT_WIDTH{1'b0}};
        n_uncorrectable <= {CNT_WIDTH{1'b0}};
        n_misalign      <= {CNT_WIDTH{1'b0}};
      end else begin
        n_corrected     <= sat_add(n_corrected, ncorr_r);
        n_uncorrectable <= sat_add(n_uncorrectable, {1'b0, uncorr_r});
        n_misalign      <= sat_add(n_misalign, {1'b0, misalign_evt_s});
      end
    end
  end

endmodule

// File: tb/tb_fast_control_rx.sv
// Directed bench for fast_control_rx. Orbit length 45, BCR words in slot 0
// of each orbit; outputs for the word driven in slot s are sampled after the
// tick of slot s+2 (three clock edges after the word was presented).
module tb_fast_control_rx;

  logic        clk_bx = 1'b0;
  logic        reset;
  logic [15:0] fc_stream_enc;
  logic [11:0] orb_length;
  logic        cnt_clear;
  logic        bcr, l1a, link_reset, buffer_clear;
  logic [3:0]  fc_aux;
  logic [11:0] bx_id;
  logic        locked;
  logic        dec_err;
  logic [15:0] n_corrected, n_uncorrectable, n_misalign;

  int n_checks = 0;
  int n_errors = 0;

  fast_control_rx #(.LOCK_COUNT(4), .CNT_WIDTH(16)) dut (
    .clk_bx(clk_bx), .reset(reset), .fc_stream_enc(fc_stream_enc),
    .orb_length(orb_length), .cnt_clear(cnt_clear),
    .bcr(bcr), .l1a(l1a), .link_reset(link_reset), .buffer_clear(buffer_clear),
    .fc_aux(fc_aux), .bx_id(bx_id), .locked(locked), .dec_err(dec_err),
    .n_corrected(n_corrected), .n_uncorrectable(n_uncorrectable),
    .n_misalign(n_misalign)
  );

  always #5 clk_bx = ~clk_bx;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input logic [15:0] w);
    fc_stream_enc = w;
    @(posedge clk_bx);
    #1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_bcr"},     32'(bcr),             32'd0);
    chk({tag, "_l1a"},     32'(l1a),             32'd0);
    chk({tag, "_lreset"},  32'(link_reset),      32'd0);
    chk({tag, "_bclear"},  32'(buffer_clear),    32'd0);
    chk({tag, "_aux"},     32'(fc_aux),          32'd0);
    chk({tag, "_bx"},      32'(bx_id),           32'd0);
    chk({tag, "_locked"},  32'(locked),          32'd0);
    chk({tag, "_dec_err"}, 32'(dec_err),         32'd0);
    chk({tag, "_ncorr"},   32'(n_corrected),     32'd0);
    chk({tag, "_nunc"},    32'(n_uncorrectable), 32'd0);
    chk({tag, "_nmis"},    32'(n_misalign),      32'd0);
  endtask

  // One 45-BX orbit: w0 in slot 0, optional extra word in sp_slot.
  // elock < 0 skips the lock check for that orbit.
  task automatic orbit(input logic [15:0] w0, input logic ebcr, input logic edec,
                       input int elock, input int sp_slot, input logic [15:0] sp_word,
                       input logic sp_bcr, input logic sp_l1a, input logic [11:0] sp_bx);
    for (int s = 0; s < 45; s++) begin
      if (s == 0) tick(w0);
      else if (s == sp_slot) tick(sp_word);
      else tick(16'h0000);
      if (s == 2) begin
        chk("slot0_bcr",     32'(bcr),     32'(ebcr));
        chk("slot0_dec_err", 32'(dec_err), 32'(edec));
        chk("slot0_bx",      32'(bx_id),   32'd0);
        if (elock >= 0) chk("slot0_locked", 32'(locked), 32'(elock));
      end
      if (s == 3) begin
        chk("bcr_one_cycle",     32'(bcr),     32'd0);
        chk("dec_err_one_cycle", 32'(dec_err), 32'd0);
      end
      if (sp_slot > 0 && s == sp_slot + 2) begin
        chk("sp_bcr",    32'(bcr),          32'(sp_bcr));
        chk("sp_l1a",    32'(l1a),          32'(sp_l1a));
        chk("sp_lreset", 32'(link_reset),   32'd0);
        chk("sp_bclear", 32'(buffer_clear), 32'd0);
        chk("sp_bx",     32'(bx_id),        32'(sp_bx));
      end
      if (sp_slot > 0 && s == sp_slot + 3) begin
        chk("sp_l1a_one_cycle", 32'(l1a), 32'd0);
        chk("sp_bcr_one_cycle", 32'(bcr), 32'd0);
      end
    end
  endtask

  initial begin
    reset         = 1'b1;
    fc_stream_enc = 16'h0000;
    orb_length    = 12'd45;
    cnt_clear     = 1'b0;
    repeat (2) @(posedge clk_bx);
    #1;
    chk_all_zero("reset");
    reset = 1'b0;

    // Lock acquisition: BCR in slot 0 of every orbit.
    orbit(16'h000F, 1'b1, 1'b0, -1, -1, 16'h0000, 1'b0, 1'b0, 12'd0);
    orbit(16'h000F, 1'b1, 1'b0, -1, -1, 16'h0000, 1'b0, 1'b0, 12'd0);
    orbit(16'h000F, 1'b1, 1'b0,  0, -1, 16'h0000, 1'b0, 1'b0, 12'd0);
    orbit(16'h000F, 1'b1, 1'b0, -1, -1, 16'h0000, 1'b0, 1'b0, 12'd0);
    orbit(16'h000F, 1'b1, 1'b0,  1, -1, 16'h0000, 1'b0, 1'b0, 12'd0);
    chk("lock_ncorr", 32'(n_corrected),     32'd0);
    chk("lock_nunc",  32'(n_uncorrectable), 32'd0);
    chk("lock_nmis",  32'(n_misalign),      32'd0);

    // L1A at slot 10 while locked.
    orbit(16'h000F, 1'b1, 1'b0, 1, 10, 16'h0033, 1'b0, 1'b1, 12'd10);

    // Single-bit errors on BCR words: parity bit e0, then p2 (e2).
    orbit(16'h000E, 1'b1, 1'b0, 1, -1, 16'h0000, 1'b0, 1'b0, 12'd0);
    chk("corr_e0", 32'(n_corrected), 32'd1);
    orbit(16'h000B, 1'b1, 1'b0, 1, -1, 16'h0000, 1'b0, 1'b0, 12'd0);
    chk("corr_e2", 32'(n_corrected), 32'd2);

    // Uncorrectable word at a BCR slot: no BCR, wrap drops the lock.
    orbit(16'h0003, 1'b0, 1'b1, 0, -1, 16'h0000, 1'b0, 1'b0, 12'd0);
    chk("unc_nunc",  32'(n_uncorrectable), 32'd1);
    chk("unc_nmis",  32'(n_misalign),      32'd1);
    chk("unc_ncorr", 32'(n_corrected),     32'd2);

    // Relock.
    orbit(16'h000F, 1'b1, 1'b0,  0, -1, 16'h0000, 1'b0, 1'b0, 12'd0);
    orbit(16'h000F, 1'b1, 1'b0, -1, -1, 16'h0000, 1'b0, 1'b0, 12'd0);
    orbit(16'h000F, 1'b1, 1'b0,  0, -1, 16'h0000, 1'b0, 1'b0, 12'd0);
    orbit(16'h000F, 1'b1, 1'b0, -1, -1, 16'h0000, 1'b0, 1'b0, 12'd0);
    orbit(16'h000F, 1'b1, 1'b0,  1, -1, 16'h0000, 1'b0, 1'b0, 12'd0);

    // Misaligned BCR at bx 20 while locked.
    orbit(16'h000F, 1'b1, 1'b0, 1, 20, 16'h000F, 1'b1, 1'b0, 12'd0);
    chk("mis_locked", 32'(locked),     32'd0);
    chk("mis_nmis",   32'(n_misalign), 32'd2);
    orbit(16'h000F, 1'b1, 1'b0,  0, -1, 16'h0000, 1'b0, 1'b0, 12'd0);
    orbit(16'h000F, 1'b1, 1'b0,  0, -1, 16'h0000, 1'b0, 1'b0, 12'd0);
    orbit(16'h000F, 1'b1, 1'b0, -1, -1, 16'h0000, 1'b0, 1'b0, 12'd0);
    orbit(16'h000F, 1'b1, 1'b0, -1, -1, 16'h0000, 1'b0, 1'b0, 12'd0);
    orbit(16'h000F, 1'b1, 1'b0,  1, -1, 16'h0000, 1'b0, 1'b0, 12'd0);
    chk("pre_clr_nunc",  32'(n_uncorrectable), 32'd1);
    chk("pre_clr_ncorr", 32'(n_corrected),     32'd2);

    // Aux update (missing BCR drops lock), aux hold, cnt_clear vs increment.
    tick(16'h5A00);
    tick(16'h0003);
    tick(16'h0000);
    chk("aux_update",   32'(fc_aux),     32'h5);
    chk("aux_nmis",     32'(n_misalign), 32'd3);
    chk("aux_unlocked", 32'(locked),     32'd0);
    cnt_clear = 1'b1;
    tick(16'h00C3);
    cnt_clear = 1'b0;
    chk("clr_dec_err", 32'(dec_err),         32'd1);
    chk("clr_nunc",    32'(n_uncorrectable), 32'd0);
    chk("clr_nmis",    32'(n_misalign),      32'd0);
    chk("clr_ncorr",   32'(n_corrected),     32'd0);
    chk("aux_hold",    32'(fc_aux),          32'h5);
    chk("clr_bx",      32'(bx_id),           32'd1);
    tick(16'h0000);
    chk("clr_dec_err_end", 32'(dec_err),         32'd0);
    chk("clr_nunc_stays",  32'(n_uncorrectable), 32'd0);
    tick(16'h0000);
    chk("cmd_c_lreset", 32'(link_reset),   32'd1);
    chk("cmd_c_bclear", 32'(buffer_clear), 32'd1);
    chk("cmd_c_bcr",    32'(bcr),          32'd0);
    chk("cmd_c_l1a",    32'(l1a),          32'd0);
    chk("cmd_c_bx",     32'(bx_id),        32'd3);

    // Asynchronous reset mid-orbit.
    #3;
    reset = 1'b1;
    #1;
    chk_all_zero("async_reset");
    @(posedge clk_bx);
    #1;
    reset = 1'b0;

    // Degenerate orbit length: bx_id held at 0, no lock, strobes still pass.
    orb_length = 12'd1;
    tick(16'h000F);
    tick(16'h0000);
    tick(16'h0000);
    chk("orb1_bcr",    32'(bcr),    32'd1);
    chk("orb1_bx",     32'(bx_id),  32'd0);
    chk("orb1_locked", 32'(locked), 32'd0);
    tick(16'h0000);
    chk("orb1_bx_hold", 32'(bx_id), 32'd0);
    orb_length = 12'd45;
    tick(16'h0000);
    tick(16'h0000);
    chk("orb45_resume_bx", 32'(bx_id), 32'd2);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
